fuzzifier_trap_seq: RTL and testbench
=====================================

FUZZIFIER_TRAP_SEQ -- requirements
Module: fuzzifier_trap_seq

Interface
REQ-001 The block SHALL have parameter W, default 8, giving the signed crisp-input and MF-breakpoint width in Q(W-1).0.
REQ-002 The block SHALL have parameter N_MF, default 3, giving the number of trapezoidal MFs, legal range 1..8.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 cfg_we  input  1  breakpoint write strobe.
REQ-007 cfg_idx  input  3  MF index, 0..N_MF-1.
REQ-008 cfg_sel  input  2  breakpoint select: 0=a, 1=b, 2=c, 3=d.
REQ-009 cfg_data  input  W  signed breakpoint value.
REQ-010 cfg_ready  output  1  high when a configuration write is accepted (IDLE only).
REQ-011 in_valid  input  1  crisp sample valid.
REQ-012 in_ready  output  1  block can accept a sample.
REQ-013 x  input  W  signed crisp sample.
REQ-014 out_valid  output  1  membership vector valid.
REQ-015 out_ready  input  1  consumer accepts the vector.
REQ-016 mu  output  16*N_MF  Q1.15 degrees, MF k in bits [16k+15:16k].

Function
REQ-017 The FSM SHALL have the states IDLE, CLASSIFY, DIVIDE and DONE.
REQ-018 in_ready and cfg_ready SHALL equal (state==IDLE).
REQ-019 A config write with cfg_we=1 in IDLE and cfg_idx<N_MF SHALL update the selected breakpoint at the next edge.
- Writes with cfg_idx>=N_MF are dropped.
- Writes outside IDLE are dropped.
REQ-020 On in_valid&&in_ready, the block SHALL register x, set the MF counter k=0 and go to CLASSIFY.
REQ-021 CLASSIFY SHALL take one cycle and evaluate MF k in strict priority order:
- (x<=a)||(x>=d) gives 0.
- (x>=b)&&(x<=c) gives 0x7FFF.
- a<x<b is a rising slope: num=(x-a), den=(b-a).
- Otherwise a falling slope: num=(d-x), den=(d-c).
REQ-022 The slope operands SHALL be computed at W+1 bits signed; den==0 SHALL be replaced by 1.
REQ-023 DIVIDE SHALL run an unsigned restoring division (num<<15)/den for exactly 16 cycles, one quotient bit per cycle.
- It runs for flat and zero regions too, with the result forced, so latency is fixed.
REQ-024 The division result SHALL saturate to 0x7FFF, so mu never exceeds 0x7FFF.
REQ-025 After DIVIDE, the block SHALL write mu[k] and then either increment k and return to CLASSIFY, or go to DONE when k==N_MF-1.
REQ-026 Latency SHALL be fixed: out_valid rises exactly 17*N_MF+1 cycles after the accepting edge (52 for N_MF=3).
REQ-027 In DONE, out_valid=1 and mu SHALL hold stable until out_ready=1, then the FSM returns to IDLE at the next edge.
- No new sample is accepted in the same cycle.
REQ-028 mu SHALL change only at per-MF write-back and SHALL hold its last vector while in IDLE.
REQ-029 x=-2^(W-1) and x=2^(W-1)-1 SHALL be handled without overflow.
REQ-030 Reversed breakpoints (for example a>b) SHALL follow the REQ-021 priority without special casing.

Reset
REQ-031 Asserting rst_n=0 at any time, including mid-DIVIDE, SHALL immediately clear the following:
- State to IDLE.
- out_valid=0 and mu=0.
- All breakpoints to 0.
- k, quotient and remainder registers to 0.
REQ-032 After reset deassertion, in_ready=1 and cfg_ready=1 in the first cycle.

Verification
REQ-033 Configure neg(-100,-50,-30,-5), zero(-10,0,0,10), pos(5,25,35,60) and send x=-40 -> after 52 cycles mu_neg=0x7FFF, mu_zero=0, mu_pos=0.
REQ-034 Same configuration, x=5 then x=15:
- x=5 -> mu_neg=0, mu_zero=16384, mu_pos=0.
- x=15 -> mu_neg=0, mu_zero=0, mu_pos=16384.
REQ-035 Same configuration, x=-128 and x=127 -> all mu=0, and no mu value is ever above 0x7FFF.
REQ-036 Hold out_ready=0 for 10 cycles in DONE -> mu stable, in_ready=0, and a cfg_we pulse is dropped (readback via a later sample is unchanged).
REQ-037 Pull rst_n low at cycle 20 of a transaction -> out_valid=0, mu=0 and in_ready=1 after release; a subsequent sample gives all mu=0.
REQ-038 N_MF=8, W=12 with random ordered breakpoints -> all 8 mu values match the REQ-021 model bit-exactly, with latency 137 cycles.

Source files
------------

// File: rtl/fuzzifier_trap_seq.sv
// -----------------------------------------------------------------------------
// fuzzifier_trap_seq
//
// Sequential fuzzifier. It evaluates N_MF trapezoidal membership functions
// against one signed crisp sample, one MF at a time. Each MF takes one
// classification cycle and a 16-cycle restoring division. The division always
// runs, so the latency does not depend on the data: out_valid rises
// 17*N_MF+1 cycles after the edge that accepts the sample.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   cfg_we     breakpoint write strobe (honoured in IDLE only)
//   cfg_idx    MF index 0..N_MF-1 (larger indices are ignored)
//   cfg_sel    breakpoint select: 0=a, 1=b, 2=c, 3=d
//   cfg_data   signed breakpoint value, Q(W-1).0
//   cfg_ready  high while a configuration write would be accepted
//   in_valid   crisp sample valid
//   in_ready   block can accept a sample
//   x          signed crisp sample, Q(W-1).0
//   out_valid  membership vector valid
//   out_ready  consumer accepts the vector
//   mu         Q1.15 degrees, MF k in bits [16k+15:16k]
// -----------------------------------------------------------------------------
module fuzzifier_trap_seq #(
    parameter int W    = 8,
    parameter int N_MF = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cfg_we,
    input  logic [2:0]           cfg_idx,
    input  logic [1:0]           cfg_sel,
    input  logic [W-1:0]         cfg_data,
    output logic                 cfg_ready,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [W-1:0]         x,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [16*N_MF-1:0]   mu
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLASSIFY,
        S_DIVIDE,
        S_DONE
    } state_t;

    typedef enum logic [1:0] {
        R_ZERO,
        R_FLAT,
        R_SLOPE
    } region_t;

    localparam logic [3:0]  N_MF_L  = 4'(N_MF);
    localparam logic [2:0]  K_LAST  = 3'(N_MF - 1);
    localparam logic [15:0] MU_ONE  = 16'h7FFF;

    // Quotient bit 15 set means the ratio reached 1.0, which Q1.15 cannot hold.
    function automatic logic [15:0] sat_q15(input logic [15:0] q);
        sat_q15 = q[15] ? MU_ONE : q;
    endfunction

    // Flat and zero regions still spend the division cycles; only the slope
    // region uses the computed quotient.
    function automatic logic [15:0] mu_value(input region_t region, input logic [15:0] q);
        case (region)
            R_ZERO:  mu_value = 16'h0000;
            R_FLAT:  mu_value = MU_ONE;
            default: mu_value = sat_q15(q);
        endcase
    endfunction

    state_t state_q, state_d;

    logic signed [W-1:0] x_q;
    logic signed [W-1:0] bp_a_q [N_MF];
    logic signed [W-1:0] bp_b_q [N_MF];
    logic signed [W-1:0] bp_c_q [N_MF];
    logic signed [W-1:0] bp_d_q [N_MF];
    logic [2:0]          k_q;
    logic [3:0]          cnt_q;
    region_t             region_q;
    logic [W+1:0]        rem_q;
    logic [W:0]          den_q;
    logic [15:0]         quo_q;
    logic [16*N_MF-1:0]  mu_q;
    logic                out_valid_q;

    // ---------------------------------------------------------------------
    // Breakpoint selection for the MF currently being evaluated
    // ---------------------------------------------------------------------
    logic signed [W-1:0] a_sel, b_sel, c_sel, d_sel;

    always_comb begin
        a_sel = bp_a_q[0];
        b_sel = bp_b_q[0];
        c_sel = bp_c_q[0];
        d_sel = bp_d_q[0];
        for (int g = 0; g < N_MF; g++) begin
            if (k_q == 3'(g)) begin
                a_sel = bp_a_q[g];
                b_sel = bp_b_q[g];
                c_sel = bp_c_q[g];
                d_sel = bp_d_q[g];
            end
        end
    end

    // ---------------------------------------------------------------------
    // Classification, one extra bit so x-a etc. cannot overflow
    // ---------------------------------------------------------------------
    logic signed [W:0] xe, ae, be, ce, de;
    logic signed [W:0] num_c, den_c;
    region_t           region_c;

    assign xe = {x_q[W-1], x_q};
    assign ae = {a_sel[W-1], a_sel};
    assign be = {b_sel[W-1], b_sel};
    assign ce = {c_sel[W-1], c_sel};
    assign de = {d_sel[W-1], d_sel};

    always_comb begin
        region_c = R_ZERO;
        num_c    = '0;
        den_c    = (W+1)'(1);
        if ((xe <= ae) || (xe >= de)) begin
            region_c = R_ZERO;
        end else if ((xe >= be) && (xe <= ce)) begin
            region_c = R_FLAT;
        end else if (xe < be) begin
            // a < x < b holds here because x <= a was excluded above
            region_c = R_SLOPE;
            num_c    = xe - ae;
            den_c    = be - ae;
        end else begin
            region_c = R_SLOPE;
            num_c    = de - xe;
            den_c    = de - ce;
        end
        if (den_c == '0) begin
            den_c = (W+1)'(1);
        end
    end

    // ---------------------------------------------------------------------
    // One restoring-division step. The remainder starts at num rather than
    // at zero: in the slope region num < den, so the 16 quotient bits are
    // exactly floor((num << 15) / den) without shifting in the 15 zero bits.
    // ---------------------------------------------------------------------
    logic [W+1:0] den_ext;
    logic         div_ge;
    logic [W+1:0] rem_sub;
    logic [W+1:0] rem_d;
    logic [15:0]  quo_d;

    assign den_ext = {1'b0, den_q};
    assign div_ge  = (rem_q >= den_ext);
    assign rem_sub = div_ge ? (rem_q - den_ext) : rem_q;
    assign rem_d   = rem_sub << 1;
    assign quo_d   = (quo_q << 1) | {15'b0, div_ge};

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = S_CLASSIFY;
                end
            end
            S_CLASSIFY: begin
                state_d = S_DIVIDE;
            end
            S_DIVIDE: begin
                if (cnt_q == 4'd15) begin
                    state_d = (k_q == K_LAST) ? S_DONE : S_CLASSIFY;
                end
            end
            S_DONE: begin
                // The first DONE cycle raises out_valid; the handshake is
                // only taken once the vector is actually presented.
                if (out_valid_q && out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------------
    always_comb begin
        in_ready  = (state_q == S_IDLE);
        cfg_ready = (state_q == S_IDLE);
        out_valid = out_valid_q;
    end

    assign mu = mu_q;

    // ---------------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------------
    logic cfg_wr;
    assign cfg_wr = cfg_we && (state_q == S_IDLE) && ({1'b0, cfg_idx} < N_MF_L);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q         <= '0;
            k_q         <= '0;
            cnt_q       <= '0;
            region_q    <= R_ZERO;
            rem_q       <= '0;
            den_q       <= '0;
            quo_q       <= '0;
            mu_q        <= '0;
            out_valid_q <= 1'b0;
            for (int g = 0; g < N_MF; g++) begin
                bp_a_q[g] <= '0;
                bp_b_q[g] <= '0;
                bp_c_q[g] <= '0;
                bp_d_q[g] <= '0;
            end
        end else begin
            for (int g = 0; g < N_MF; g++) begin
                if (cfg_wr && ({1'b0, cfg_idx} == 4'(g))) begin
                    case (cfg_sel)
                        2'd0:    bp_a_q[g] <= cfg_data;
                        2'd1:    bp_b_q[g] <= cfg_data;
                        2'd2:    bp_c_q[g] <= cfg_data;
                        default: bp_d_q[g] <= cfg_data;
                    endcase
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        x_q <= x;
                        k_q <= '0;
                    end
                end
                S_CLASSIFY: begin
                    region_q <= region_c;
                    rem_q    <= {1'b0, num_c};
                    den_q    <= den_c;
                    quo_q    <= '0;
                    cnt_q    <= '0;
                end
                S_DIVIDE: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + 4'd1;
                    if (cnt_q == 4'd15) begin
                        for (int g = 0; g < N_MF; g++) begin
                            if (k_q == 3'(g)) begin
                                mu_q[16*g +: 16] <= mu_value(region_q, quo_d);
                            end
                        end
                        if (k_q != K_LAST) begin
                            k_q <= k_q + 3'd1;
                        end
                    end
                end
                S_DONE: begin
                    if (!out_valid_q) begin
                        out_valid_q <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fuzzifier_trap_seq.sv
module tb_fuzzifier_trap_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    // DUT A: default W=8, N_MF=3
    logic        cfg_we, cfg_ready, in_valid, in_ready, out_valid, out_ready;
    logic [2:0]  cfg_idx;
    logic [1:0]  cfg_sel;
    logic [7:0]  cfg_data, x;
    logic [47:0] mu;

    // DUT B: W=12, N_MF=8
    logic         b_cfg_we, b_cfg_ready, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [2:0]   b_cfg_idx;
    logic [1:0]   b_cfg_sel;
    logic [11:0]  b_cfg_data, b_x;
    logic [127:0] b_mu;

    int n_tests = 0;
    int n_fail  = 0;

    fuzzifier_trap_seq #(.W(8), .N_MF(3)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready),
        .in_valid(in_valid), .in_ready(in_ready), .x(x),
        .out_valid(out_valid), .out_ready(out_ready), .mu(mu)
    );

    fuzzifier_trap_seq #(.W(12), .N_MF(8)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .cfg_we(b_cfg_we), .cfg_idx(b_cfg_idx), .cfg_sel(b_cfg_sel), .cfg_data(b_cfg_data),
        .cfg_ready(b_cfg_ready),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .x(b_x),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .mu(b_mu)
    );

    // Reference trapezoid evaluation
    function automatic int model(int xv, int a, int b, int c, int d);
        int num, den, q;
        if (xv <= a || xv >= d) return 0;
        if (xv >= b && xv <= c) return 32767;
        if (xv < b) begin
            num = xv - a; den = b - a;
        end else begin
            num = d - xv; den = d - c;
        end
        if (den == 0) den = 1;
        q = (num * 32768) / den;
        if (q > 32767) q = 32767;
        return q;
    endfunction

    task automatic cfg_a(input int idx, input int sel, input int val);
        @(negedge clk);
        cfg_we = 1'b1; cfg_idx = 3'(idx); cfg_sel = 2'(sel); cfg_data = 8'(val);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic cfg_mf_a(input int idx, input int a, input int b, input int c, input int d);
        cfg_a(idx, 0, a); cfg_a(idx, 1, b); cfg_a(idx, 2, c); cfg_a(idx, 3, d);
    endtask

    task automatic sample_a(input int xv, input bit release_out, output logic [47:0] m, output int lat);
        @(negedge clk);
        x = 8'(xv); in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        m = mu;
        if (release_out) begin
            @(negedge clk); out_ready = 1'b1;
            @(negedge clk); out_ready = 1'b0;
        end
    endtask

    task automatic cfg_b(input int idx, input int sel, input int val);
        @(negedge clk);
        b_cfg_we = 1'b1; b_cfg_idx = 3'(idx); b_cfg_sel = 2'(sel); b_cfg_data = 12'(val);
        @(negedge clk);
        b_cfg_we = 1'b0;
    endtask

    task automatic sample_b(input int xv, output logic [127:0] m, output int lat);
        @(negedge clk);
        b_x = 12'(xv); b_in_valid = 1'b1;
        @(posedge clk);
        #1;
        b_in_valid = 1'b0;
        lat = 0;
        while (b_out_valid !== 1'b1 && lat < 400) begin
            @(posedge clk);
            #1;
            lat++;
        end
        m = b_mu;
        @(negedge clk); b_out_ready = 1'b1;
        @(negedge clk); b_out_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_tests++;
        if (mu !== 48'h0) begin n_fail++; $display("FAIL reset_mu: got %h expected 0", mu); end
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        n_tests++;
        if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cfg_ready: got %b expected 1", cfg_ready); end
    endtask

    task automatic test_basic;
        logic [47:0] m;
        int lat;
        int xs [3]      = '{-40, 5, 15};
        int exp_mu [9]  = '{32767, 0, 0,   0, 16384, 0,   0, 0, 16384};
        cfg_mf_a(0, -100, -50, -30, -5);
        cfg_mf_a(1, -10, 0, 0, 10);
        cfg_mf_a(2, 5, 25, 35, 60);
        for (int s = 0; s < 3; s++) begin
            sample_a(xs[s], 1'b1, m, lat);
            n_tests++;
            if (lat != 52) begin n_fail++; $display("FAIL basic_latency x=%0d: got %0d expected 52", xs[s], lat); end
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (m[16*k +: 16] !== 16'(exp_mu[3*s+k])) begin
                    n_fail++;
                    $display("FAIL basic_mu x=%0d k=%0d: got %0d expected %0d", xs[s], k, m[16*k +: 16], exp_mu[3*s+k]);
                end
            end
            n_tests++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_fail++; $display("FAIL basic_release x=%0d: out_valid=%b in_ready=%b expected 0/1", xs[s], out_valid, in_ready);
            end
            n_tests++;
            if (mu !== m) begin n_fail++; $display("FAIL basic_idle_hold x=%0d: got %h expected %h", xs[s], mu, m); end
        end
    endtask

    task automatic test_boundary;
        logic [47:0] m;
        int lat;
        int xs [2] = '{-128, 127};
        for (int s = 0; s < 2; s++) begin
            sample_a(xs[s], 1'b1, m, lat);
            n_tests++;
            if (m !== 48'h0) begin n_fail++; $display("FAIL boundary_mu x=%0d: got %h expected 0", xs[s], m); end
            n_tests++;
            if (lat != 52) begin n_fail++; $display("FAIL boundary_latency x=%0d: got %0d expected 52", xs[s], lat); end
        end
    endtask

    task automatic test_hold;
        logic [47:0] m, m2;
        int lat;
        sample_a(5, 1'b0, m, lat);
        n_tests++;
        if (m !== {16'd0, 16'd16384, 16'd0}) begin n_fail++; $display("FAIL hold_first: got %h expected 000040000000", m); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (i == 0) begin
                cfg_we = 1'b1; cfg_idx = 3'd0; cfg_sel = 2'd1; cfg_data = 8'd100;
            end else begin
                cfg_we = 1'b0;
            end
            n_tests++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || cfg_ready !== 1'b0 || mu !== m) begin
                n_fail++;
                $display("FAIL hold_cycle%0d: out_valid=%b in_ready=%b cfg_ready=%b mu=%h expected 1/0/0 mu=%h",
                         i, out_valid, in_ready, cfg_ready, mu, m);
            end
        end
        @(negedge clk); cfg_we = 1'b0; out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        n_tests++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || mu !== m) begin
            n_fail++; $display("FAIL hold_release: out_valid=%b in_ready=%b mu=%h expected 0/1 mu=%h", out_valid, in_ready, mu, m);
        end
        // an out-of-range index must not land on any MF
        cfg_a(4, 1, 100);
        sample_a(-40, 1'b1, m2, lat);
        n_tests++;
        if (m2 !== {16'd0, 16'd0, 16'h7FFF}) begin
            n_fail++; $display("FAIL hold_dropped_cfg: got %h expected 000000007fff", m2);
        end
    endtask

    task automatic test_extremes;
        logic [47:0] m;
        int lat;
        int xs [3]     = '{126, 35, -127};
        int exp_mu [9] = '{32639, 32767, 0,   20945, 32767, 16384,   128, 32767, 0};
        cfg_mf_a(0, -128, 127, 127, 127);
        cfg_mf_a(1, -128, -128, 127, 127);
        cfg_mf_a(2, 20, 10, 30, 40);
        for (int s = 0; s < 3; s++) begin
            sample_a(xs[s], 1'b1, m, lat);
            for (int k = 0; k < 3; k++) begin
                n_tests++;
                if (m[16*k +: 16] !== 16'(exp_mu[3*s+k])) begin
                    n_fail++;
                    $display("FAIL extreme_mu x=%0d k=%0d: got %0d expected %0d", xs[s], k, m[16*k +: 16], exp_mu[3*s+k]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        logic [47:0] m;
        int lat;
        @(negedge clk);
        x = 8'd35; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++;
        if (out_valid !== 1'b0 || mu !== 48'h0) begin
            n_fail++; $display("FAIL midreset_clear: out_valid=%b mu=%h expected 0/0", out_valid, mu);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_tests++;
        if (in_ready !== 1'b1 || cfg_ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset_ready: in_ready=%b cfg_ready=%b expected 1/1", in_ready, cfg_ready);
        end
        sample_a(35, 1'b1, m, lat);
        n_tests++;
        if (m !== 48'h0) begin n_fail++; $display("FAIL midreset_sample: got %h expected 0", m); end
        n_tests++;
        if (lat != 52) begin n_fail++; $display("FAIL midreset_latency: got %0d expected 52", lat); end
    endtask

    task automatic test_wide;
        int ba [8], bb [8], bc [8], bd [8];
        int v [4];
        int xs [5];
        int t, lat, e;
        logic [127:0] m;
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 4; j++) v[j] = int'($urandom_range(0, 4095)) - 2048;
            for (int i = 0; i < 3; i++)
                for (int j = 0; j < 3 - i; j++)
                    if (v[j] > v[j+1]) begin t = v[j]; v[j] = v[j+1]; v[j+1] = t; end
            ba[k] = v[0]; bb[k] = v[1]; bc[k] = v[2]; bd[k] = v[3];
            cfg_b(k, 0, ba[k]); cfg_b(k, 1, bb[k]); cfg_b(k, 2, bc[k]); cfg_b(k, 3, bd[k]);
        end
        xs[0] = -2048;
        xs[1] = 2047;
        xs[2] = (ba[0] + bb[0]) / 2;
        xs[3] = (bc[3] + bd[3]) / 2;
        xs[4] = (bb[6] + bc[6]) / 2;
        for (int s = 0; s < 5; s++) begin
            sample_b(xs[s], m, lat);
            n_tests++;
            if (lat != 137) begin n_fail++; $display("FAIL wide_latency x=%0d: got %0d expected 137", xs[s], lat); end
            for (int k = 0; k < 8; k++) begin
                e = model(xs[s], ba[k], bb[k], bc[k], bd[k]);
                n_tests++;
                if (m[16*k +: 16] !== 16'(e)) begin
                    n_fail++;
                    $display("FAIL wide_mu x=%0d k=%0d: got %0d expected %0d", xs[s], k, m[16*k +: 16], e);
                end
            end
        end
    endtask

    initial begin
        cfg_we = 1'b0; cfg_idx = '0; cfg_sel = '0; cfg_data = '0;
        in_valid = 1'b0; x = '0; out_ready = 1'b0;
        b_cfg_we = 1'b0; b_cfg_idx = '0; b_cfg_sel = '0; b_cfg_data = '0;
        b_in_valid = 1'b0; b_x = '0; b_out_ready = 1'b0;
        test_reset();
        test_basic();
        test_boundary();
        test_hold();
        test_extremes();
        test_reset_mid();
        test_wide();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
